// File: rtl/tick_counter_pkg.sv
// Shared constants and helpers for the tick_counter block.
// Optional input synchroniser is enabled by defining TICK_COUNTER_SYNC_EN.
package tick_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Register width able to hold 0..value-1, never narrower than one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/tick_counter_if.sv
// Control and status bundle of tick_counter. All controls are level signals
// sampled on rising clock edges; there is no valid/ready handshake.
interface tick_counter_if #(
  parameter int WIDTH = 8
);
  logic             iEN;
  logic             iDIR;
  logic             iSAT;
  logic             iCLR;
  logic             iLOAD;
  logic [WIDTH-1:0] iLOAD_VAL;
  logic [WIDTH-1:0] oCOUNT;
  logic             oTICK;
  logic             oTC;

  modport master (
    output iEN, iDIR, iSAT, iCLR, iLOAD, iLOAD_VAL,
    input  oCOUNT, oTICK, oTC
  );

  modport slave (
    input  iEN, iDIR, iSAT, iCLR, iLOAD, iLOAD_VAL,
    output oCOUNT, oTICK, oTC
  );
endinterface

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV counter producing a single-cycle tick enable.
module tick_prescaler
  import tick_counter_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic iCLK_50,
  input  logic iRST,
  input  logic iCLR,
  output logic oTICK_INT
);
  localparam int             W    = clog2_min1(DIV);
  localparam logic [W-1:0]   LAST = W'(DIV - 1);

  logic [W-1:0] pre;

  // With DIV==1 LAST is 0, so the tick is asserted every cycle.
  assign oTICK_INT = (pre == LAST);

  always_ff @(posedge iCLK_50) begin
    if (iRST || iCLR) begin
      pre <= '0;
    end else if (oTICK_INT) begin
      pre <= '0;
    end else begin
      pre <= pre + W'(1);
    end
  end
endmodule

// File: rtl/tick_counter.sv
// Tick-driven up/down counter with wrap/saturate, clear, load and terminal
// count. Define TICK_COUNTER_SYNC_EN to insert 2-flop input synchronisers.
module tick_counter
  import tick_counter_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1,
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 2**WIDTH - 1
) (
  input logic          iCLK_50,
  input logic          iRST,
  tick_counter_if.slave bus
);
  localparam int               DIV   = CLK_HZ / TICK_HZ;
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  logic en, dir, sat, clr, load;
  logic tick;
  logic [WIDTH-1:0] count;
  logic tick_q, tc_q;

`ifdef TICK_COUNTER_SYNC_EN
  logic [4:0] sync1, sync2;

  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {bus.iEN, bus.iDIR, bus.iSAT, bus.iCLR, bus.iLOAD};
      sync2 <= sync1;
    end
  end

  assign {en, dir, sat, clr, load} = sync2;
`else
  assign {en, dir, sat, clr, load} = {bus.iEN, bus.iDIR, bus.iSAT, bus.iCLR, bus.iLOAD};
`endif

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .iCLK_50   (iCLK_50),
    .iRST      (iRST),
    .iCLR      (clr),
    .oTICK_INT (tick)
  );

  always_ff @(posedge iCLK_50) begin
    if (iRST || clr) begin
      count  <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      tick_q <= tick;
      tc_q   <= 1'b0;
      if (load) begin
        // A tick landing on a load is consumed without stepping.
        count <= (bus.iLOAD_VAL > MAX_V) ? MAX_V : bus.iLOAD_VAL;
      end else if (tick && en) begin
        if (dir == DIR_UP) begin
          if (count == MAX_V) begin
            tc_q <= 1'b1;
            if (sat == MODE_WRAP) count <= '0;
          end else begin
            count <= count + WIDTH'(1);
          end
        end else begin
          if (count == '0) begin
            tc_q <= 1'b1;
            if (sat == MODE_WRAP) count <= MAX_V;
          end else begin
            count <= count - WIDTH'(1);
          end
        end
      end
    end
  end

  assign bus.oCOUNT = count;
  assign bus.oTICK  = tick_q;
  assign bus.oTC    = tc_q;
endmodule

// File: tb/tb_tick_counter.sv
// Bench for tick_counter (DIV=10, WIDTH=4, MAX_COUNT=9): vector table,
// corner sequences and random traffic against a reference model.
module tb_tick_counter;
  import tick_counter_pkg::*;

  localparam int DIV  = 10;
  localparam int W    = 4;
  localparam int MAXC = 9;
`ifdef TICK_COUNTER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct packed {
    logic en;
    logic dir;
    logic sat;
    logic clr;
    logic load;
  } ctrl_t;

  typedef struct {
    int       n;
    ctrl_t    c;
    logic [W-1:0] val;
    int       cnt;
    logic     tk;
    logic     tc;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tick_counter_if #(.WIDTH(W)) bus ();

  tick_counter #(
    .CLK_HZ(10), .TICK_HZ(1), .WIDTH(W), .MAX_COUNT(MAXC)
  ) dut (
    .iCLK_50 (clk),
    .iRST    (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard: {count, tick, tc} expected after each edge
  logic [W+1:0] exp_q[$];

  // reference model state
  int    m_count = 0;
  int    m_phase = 0;
  logic  m_tick  = 1'b0;
  logic  m_tc    = 1'b0;
  ctrl_t d1 = '0, d2 = '0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Edges since the last reset/clear; a tick lands on every DIV-th one.
  task automatic model_step(input logic r, input ctrl_t ci, input logic [W-1:0] val);
    ctrl_t c;
    logic [W+1:0] e;
    if (r) begin
      d1 = '0; d2 = '0;
      m_count = 0; m_phase = 0; m_tick = 1'b0; m_tc = 1'b0;
    end else begin
      c  = (LAT == 0) ? ci : d2;
      d2 = d1;
      d1 = ci;
      if (c.clr) begin
        m_count = 0; m_phase = 0; m_tick = 1'b0; m_tc = 1'b0;
      end else begin
        m_phase++;
        m_tick = ((m_phase % DIV) == 0);
        m_tc   = 1'b0;
        if (c.load) begin
          m_count = (int'(val) > MAXC) ? MAXC : int'(val);
        end else if (m_tick && c.en) begin
          if (c.dir) begin
            m_tc    = (m_count == MAXC);
            m_count = m_tc ? (c.sat ? MAXC : 0) : m_count + 1;
          end else begin
            m_tc    = (m_count == 0);
            m_count = m_tc ? (c.sat ? 0 : MAXC) : m_count - 1;
          end
        end
      end
    end
    e = {W'(m_count), m_tick, m_tc};
    exp_q.push_back(e);
  endtask

  // driver: one clock edge with the given inputs, checked against the model
  task automatic cycle(input logic r, input ctrl_t c, input logic [W-1:0] val);
    logic [W+1:0] e;
    rst           = r;
    bus.iEN       = c.en;
    bus.iDIR      = c.dir;
    bus.iSAT      = c.sat;
    bus.iCLR      = c.clr;
    bus.iLOAD     = c.load;
    bus.iLOAD_VAL = val;
    @(posedge clk);
    model_step(r, c, val);
    #1;
    e = exp_q.pop_front();
    check("model_count", int'(bus.oCOUNT), int'(e[W+1:2]));
    check("model_tick",  int'(bus.oTICK),  int'(e[1]));
    check("model_tc",    int'(bus.oTC),    int'(e[0]));
  endtask

  task automatic do_reset();
    cycle(1'b1, '0, '0);
    cycle(1'b1, '0, '0);
    check("reset_count", int'(bus.oCOUNT), 0);
    check("reset_tick",  int'(bus.oTICK),  0);
    check("reset_tc",    int'(bus.oTC),    0);
  endtask

  function automatic vec_t v(int n, logic en, logic dir, logic sat, logic clr,
                             logic load, int val, int cnt, logic tk, logic tc);
    vec_t x;
    x.n   = n;
    x.c   = '{en: en, dir: dir, sat: sat, clr: clr, load: load};
    x.val = W'(val);
    x.cnt = cnt;
    x.tk  = tk;
    x.tc  = tc;
    return x;
  endfunction

  vec_t tbl[$];

  initial begin
    int first, second, lat;
    ctrl_t c;

    bus.iEN = 0; bus.iDIR = 0; bus.iSAT = 0; bus.iCLR = 0; bus.iLOAD = 0;
    bus.iLOAD_VAL = '0;

`ifndef TICK_COUNTER_SYNC_EN
    //           n  en dir sat clr ld val  cnt tk tc
    tbl.push_back(v( 9, 1, 1, 0, 0, 0,  0,  0, 0, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 0,  0,  1, 1, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 0,  0,  1, 0, 0));
    tbl.push_back(v(79, 1, 1, 0, 0, 0,  0,  9, 1, 0));
    tbl.push_back(v(10, 1, 1, 0, 0, 0,  0,  0, 1, 1));
    tbl.push_back(v( 1, 1, 1, 0, 0, 0,  0,  0, 0, 0));
    tbl.push_back(v( 9, 1, 0, 1, 0, 0,  0,  0, 1, 1));
    tbl.push_back(v(10, 1, 0, 1, 0, 0,  0,  0, 1, 1));
    tbl.push_back(v( 1, 0, 0, 1, 0, 1,  5,  5, 0, 0));
    tbl.push_back(v( 9, 0, 0, 1, 0, 0,  0,  5, 1, 0));
    tbl.push_back(v(20, 0, 0, 1, 0, 0,  0,  5, 1, 0));
    tbl.push_back(v( 1, 0, 0, 1, 0, 1, 15,  9, 0, 0));
    tbl.push_back(v( 8, 1, 1, 0, 0, 0,  0,  9, 0, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 1,  3,  3, 1, 0));
    tbl.push_back(v(10, 1, 1, 0, 0, 0,  0,  4, 1, 0));
    tbl.push_back(v( 4, 1, 1, 0, 0, 0,  0,  4, 0, 0));
    tbl.push_back(v( 1, 1, 1, 0, 1, 0,  0,  0, 0, 0));
    tbl.push_back(v( 9, 1, 1, 0, 0, 0,  0,  0, 0, 0));
    tbl.push_back(v( 1, 1, 1, 0, 0, 0,  0,  1, 1, 0));
    tbl.push_back(v( 1, 1, 0, 0, 0, 0,  0,  1, 0, 0));
    tbl.push_back(v( 9, 1, 0, 0, 0, 0,  0,  0, 1, 0));
    tbl.push_back(v(10, 1, 0, 0, 0, 0,  0,  9, 1, 1));
    tbl.push_back(v( 9, 0, 0, 0, 0, 0,  0,  9, 0, 0));
    tbl.push_back(v( 1, 0, 0, 0, 1, 0,  0,  0, 0, 0));
    tbl.push_back(v(10, 1, 1, 0, 0, 0,  0,  1, 1, 0));
    tbl.push_back(v( 1, 1, 1, 1, 0, 1,  9,  9, 0, 0));
    tbl.push_back(v( 9, 1, 1, 1, 0, 0,  0,  9, 1, 1));

    do_reset();
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) cycle(1'b0, tbl[i].c, tbl[i].val);
      check($sformatf("vec%0d_count", i), int'(bus.oCOUNT), tbl[i].cnt);
      check($sformatf("vec%0d_tick", i),  int'(bus.oTICK),  int'(tbl[i].tk));
      check($sformatf("vec%0d_tc", i),    int'(bus.oTC),    int'(tbl[i].tc));
    end
`endif

    // first tick after reset release, then the tick period
    do_reset();
    first = -1; second = -1;
    c = '{en: 1'b1, dir: 1'b1, sat: 1'b0, clr: 1'b0, load: 1'b0};
    for (int k = 1; k <= 40 && second < 0; k++) begin
      cycle(1'b0, c, '0);
      if (bus.oTICK) begin
        if (first < 0) first = k;
        else second = k;
      end
    end
    check("first_tick_cycle", first, DIV);
    check("tick_period", second - first, DIV);

    // load latency measured from the first edge that sees iLOAD high
    do_reset();
    for (int k = 0; k < 3; k++) cycle(1'b0, '0, '0);
    c = '{en: 1'b0, dir: 1'b0, sat: 1'b0, clr: 1'b0, load: 1'b1};
    lat = -1;
    for (int k = 1; k <= 8 && lat < 0; k++) begin
      cycle(1'b0, c, W'(7));
      if (bus.oCOUNT == W'(7)) lat = k;
    end
    check("load_latency", lat, LAT + 1);

    // random traffic against the model
    do_reset();
    for (int k = 0; k < 800; k++) begin
      c.en   = ($urandom_range(0, 3) != 0);
      c.dir  = 1'($urandom_range(0, 1));
      c.sat  = 1'($urandom_range(0, 1));
      c.clr  = ($urandom_range(0, 39) == 0);
      c.load = ($urandom_range(0, 11) == 0);
      cycle(($urandom_range(0, 199) == 0), c, W'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/tick_counter.md
# tick_counter

Parametrised tick-driven up/down counter for board-level status and timebase use. An internal prescaler divides `iCLK_50` into a single-cycle tick enable, so no derived or ripple clock is generated. On each tick the counter steps up or down within `[0, MAX_COUNT]`, either wrapping or saturating at the limits. It also supports synchronous clear and load, and signals terminal count. Typical use: the counter drives LEDs and the control inputs come from switches.

## Interface
- `CLK_HZ`, 50_000_000: input clock frequency.
- `TICK_HZ`, 1: tick rate. `DIV = CLK_HZ/TICK_HZ`, must be ≥1 and integer.
- `WIDTH`, 8: counter width.
- `MAX_COUNT`, 2**WIDTH-1: upper count limit, must be < 2**WIDTH.
- `iCLK_50` input 1: sole clock, all logic on rising edge.
- `iRST` input 1: synchronous, active-high reset.
- `iEN` input 1: count enable, sampled on tick cycles.
- `iDIR` input 1: 1 = count up, 0 = count down.
- `iSAT` input 1: 1 = saturate at limits, 0 = wrap.
- `iCLR` input 1: synchronous clear of counter and prescaler.
- `iLOAD` input 1: load `iLOAD_VAL` into counter.
- `iLOAD_VAL` input WIDTH: load value.
- `oCOUNT` output WIDTH: current count, registered.
- `oTICK` output 1: one-cycle pulse, registered.
- `oTC` output 1: one-cycle terminal-count pulse, registered.

## Operation
- **Reset values:** `oCOUNT`=0, `oTICK`=0, `oTC`=0, prescaler=0.
- **Prescaler:**
  - Counts 0..DIV-1, width `$clog2(DIV)` (min 1).
  - Internal `tick = (pre == DIV-1)`. On the tick cycle `pre` returns to 0.
  - `DIV==1` gives a tick on every cycle.
- **Priority per edge:** `iRST` > `iCLR` > `iLOAD` > tick step.
- **`iCLR`:** counter=0, `pre`=0, `oTICK`=0, `oTC`=0.
- **`iLOAD`:**
  - Counter = min(`iLOAD_VAL`, `MAX_COUNT`).
  - Takes effect immediately, with no wait for a tick.
  - The prescaler keeps running. A tick coinciding with load is consumed (`oTICK` still pulses) but does not step the counter.
- **Tick step** (`tick && iEN`, no clear or load):
  - Up, count < MAX: +1.
  - Up, count == MAX: wrap to 0, or hold if `iSAT`. `oTC` pulses in either case.
  - Down, count > 0: -1.
  - Down, count == 0: wrap to MAX, or hold if `iSAT`. `oTC` pulses.
- **Direction and mode:** `iDIR` and `iSAT` are sampled only on the stepping edge. Changing them between ticks has no effect until the next tick.
- **`iEN`=0 on a tick:** `oTICK` still pulses, count holds, `oTC`=0.
- **Out-of-range count:** arithmetic is WIDTH-bit unsigned. The count can never exceed `MAX_COUNT`.

## Timing
- `oTICK` and the updated `oCOUNT` become visible in the same cycle, one cycle after the internal tick. `oTC` is aligned with them.
- **After reset release:** first `oTICK` is high in cycle DIV (cycle 1 = first cycle after `iRST` falls), then every DIV cycles.
- **`iCLR` / `iLOAD` latency:** `oCOUNT` updates one cycle after the request.
- **After `iCLR`:** next `oTICK` is DIV cycles after the `iCLR` cycle.
- **Reset or clear mid-operation:** aborts any pending pulse. No `oTICK` or `oTC` is emitted for the cleared cycle.

## Configuration
- **`TICK_COUNTER_SYNC_EN` defined:**
  - `iEN`, `iDIR`, `iSAT`, `iCLR` and `iLOAD` each pass through a 2-flop synchroniser (reset to 0) before use.
  - `iLOAD_VAL` is sampled directly when the synchronised `iLOAD` is seen; the source must hold it stable.
  - All control-to-output latencies grow by 2 cycles.
- **Undefined:** inputs are used directly, with the latencies stated above.

## Structure
- **Package `tick_counter_pkg`:**
  - Direction constants `DIR_UP=1'b1`, `DIR_DOWN=1'b0`.
  - Mode constants `MODE_WRAP=1'b0`, `MODE_SAT=1'b1`.
  - A `clog2_min1` function for prescaler width.
- **Sub-module `tick_prescaler`:**
  - Parameter DIV.
  - Ports `iCLK_50`, `iRST`, `iCLR`, `oTICK_INT`.
  - Instantiated once.
- Counter step logic stays in `tick_counter`.

## Test plan
Bench parameters: CLK_HZ=10, TICK_HZ=1 (DIV=10), WIDTH=4, MAX_COUNT=9.

- **Count up, wrap:** reset, `iEN`=1, `iDIR`=1, `iSAT`=0, run 110 cycles.
  - `oTICK` at cycles 10, 20, …
  - `oCOUNT` 1..9, then 0 at the 10th tick, with `oTC`=1 on that cycle only.
- **Count down, saturate:** `iDIR`=0, `iSAT`=1 from 0.
  - `oCOUNT` stays 0.
  - `oTC` pulses on every tick.
- **Load:** `iLOAD_VAL`=15 with `iLOAD`=1 → `oCOUNT`=9 next cycle (clamped).
  - Load coinciding with a tick → no step, `oTICK`=1.
- **Clear mid-period:** assert `iCLR` at cycle 5 after a tick → `oCOUNT`=0, next `oTICK` exactly 10 cycles later.
- **Enable off:** `iEN`=0 across 3 ticks → `oTICK` pulses 3×, `oCOUNT` unchanged, `oTC`=0.
- **With `TICK_COUNTER_SYNC_EN`:** repeat the load test → `oCOUNT` updates 3 cycles after `iLOAD` rises.
